// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the machine-mode interrupt controller.
package irq_pkg;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam logic [2:0] ADDR_MSIP        = 3'd0;
  localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd1;
  localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd2;
  localparam logic [2:0] ADDR_MTIME_LO    = 3'd3;
  localparam logic [2:0] ADDR_MTIME_HI    = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// Register bus and core trap handshake between irq_ctrl and its neighbours.
interface irq_ctrl_if #(parameter int XLEN = 32);
  logic            bus_we;
  logic [2:0]      bus_addr;
  logic [31:0]     bus_wdata;
  logic [31:0]     bus_rdata;
  logic            irq_req;
  logic [XLEN-1:0] irq_cause;
  logic            irq_ack;
  logic            mret;

  modport slave (
    input  bus_we, bus_addr, bus_wdata, irq_ack, mret,
    output bus_rdata, irq_req, irq_cause
  );

  modport master (
    output bus_we, bus_addr, bus_wdata, irq_ack, mret,
    input  bus_rdata, irq_req, irq_cause
  );
endinterface

// File: rtl/irq_mtimer.sv
// Prescaled 64-bit mtime, mtimecmp and the registered timer-pending compare.
module irq_mtimer
  import irq_pkg::*;
#(
  parameter int TIMER_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] rdata,
  output logic        mtip
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TIMER_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          tick;

  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      mtip      <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      mtip      <= (mtime >= mtimecmp);
      // a bus write to either half swallows a coincident increment
      if (bus_we && bus_addr == ADDR_MTIME_LO)
        mtime[31:0] <= bus_wdata;
      else if (bus_we && bus_addr == ADDR_MTIME_HI)
        mtime[63:32] <= bus_wdata;
      else if (tick)
        mtime <= mtime + 64'd1;
      if (bus_we && bus_addr == ADDR_MTIMECMP_LO)
        mtimecmp[31:0] <= bus_wdata;
      else if (bus_we && bus_addr == ADDR_MTIMECMP_HI)
        mtimecmp[63:32] <= bus_wdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus_addr)
      ADDR_MTIMECMP_LO: rdata = mtimecmp[31:0];
      ADDR_MTIMECMP_HI: rdata = mtimecmp[63:32];
      ADDR_MTIME_LO:    rdata = mtime[31:0];
      ADDR_MTIME_HI:    rdata = mtime[63:32];
      default:          rdata = '0;
    endcase
  end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: pending bits, fixed-priority arbiter and
// request/ack/mret handshake with the core.
//
// state  | meaning
// IDLE   | no request outstanding, arbitrating every cycle
// REQ    | irq_req high, cause tracks highest eligible source
// ACTIVE | trap taken, blocked until the handler retires mret
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TIMER_DIV = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ext_irq,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie_in,
  output logic [XLEN-1:0] mip_out,
  irq_ctrl_if.slave       bus
);

  irq_state_t      state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] arb_cause;
  logic            ext_meta, meip, msip, mtip;
  logic            elig_mei, elig_msi, elig_mti, any_elig;
  logic [31:0]     timer_rdata;
  logic            unused_mie;

  irq_mtimer #(.TIMER_DIV(TIMER_DIV)) u_mtimer (
    .clock     (clock),
    .reset     (reset),
    .bus_we    (bus.bus_we),
    .bus_addr  (bus.bus_addr),
    .bus_wdata (bus.bus_wdata),
    .rdata     (timer_rdata),
    .mtip      (mtip)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_meta <= 1'b0;
      meip     <= 1'b0;
      msip     <= 1'b0;
    end else begin
      ext_meta <= ext_irq;
      meip     <= ext_meta;
      if (bus.bus_we && bus.bus_addr == ADDR_MSIP)
        msip <= bus.bus_wdata[0];
    end
  end

  always_comb begin
    mip_out           = '0;
    mip_out[MIP_MSIP] = msip;
    mip_out[MIP_MTIP] = mtip;
    mip_out[MIP_MEIP] = meip;
  end

  assign elig_mei = mstatus_mie & mie_in[MIP_MEIP] & meip;
  assign elig_msi = mstatus_mie & mie_in[MIP_MSIP] & msip;
  assign elig_mti = mstatus_mie & mie_in[MIP_MTIP] & mtip;
  assign any_elig = elig_mei | elig_msi | elig_mti;

  assign unused_mie = ^{mie_in[XLEN-1:12], mie_in[10:8], mie_in[6:4], mie_in[2:0]};

  always_comb begin
    arb_cause         = '0;
    arb_cause[XLEN-1] = 1'b1;
    if (elig_mei)      arb_cause[3:0] = CAUSE_MEI;
    else if (elig_msi) arb_cause[3:0] = CAUSE_MSI;
    else               arb_cause[3:0] = CAUSE_MTI;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = REQ;
          cause_d = arb_cause;
        end
      end
      REQ: begin
        // ack beats a same-cycle withdrawal; cause is frozen at the ack
        if (bus.irq_ack) state_d = ACTIVE;
        else if (any_elig) cause_d = arb_cause;
        else state_d = IDLE;
      end
      ACTIVE: begin
        if (bus.mret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.irq_req   = (state_q == REQ);
  assign bus.irq_cause = cause_q;
  assign bus.bus_rdata = (bus.bus_addr == ADDR_MSIP) ? {31'b0, msip} : timer_rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ext_irq;
  logic        mstatus_mie;
  logic [31:0] mie_in;
  logic [31:0] mip_out, mip_out3;

  irq_ctrl_if #(.XLEN(32)) bus ();
  irq_ctrl_if #(.XLEN(32)) bus3 ();

  assign bus3.bus_we    = bus.bus_we;
  assign bus3.bus_addr  = bus.bus_addr;
  assign bus3.bus_wdata = bus.bus_wdata;
  assign bus3.irq_ack   = bus.irq_ack;
  assign bus3.mret      = bus.mret;

  irq_ctrl #(.XLEN(32), .TIMER_DIV(1)) dut (
    .clock(clock), .reset(reset), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
    .mie_in(mie_in), .mip_out(mip_out), .bus(bus)
  );

  irq_ctrl #(.XLEN(32), .TIMER_DIV(3)) dut3 (
    .clock(clock), .reset(reset), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
    .mie_in(mie_in), .mip_out(mip_out3), .bus(bus3)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_chk  = 0;

  // reference model: index 0 is the TIMER_DIV=1 instance, index 1 is TIMER_DIV=3
  int          divs[2] = '{1, 3};
  logic [63:0] m_mtime[2];
  logic [63:0] m_cmp[2];
  bit          m_mtip[2];
  int unsigned m_edges;
  bit          m_msip, m_meip, m_ext_prev;
  bit          m_req, m_busy;
  logic [31:0] m_cause;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_mip();
    logic [31:0] v = '0;
    v[11] = m_meip;
    v[7]  = m_mtip[0];
    v[3]  = m_msip;
    return v;
  endfunction

  function automatic int pick(bit gmie, logic [31:0] mie, logic [31:0] mip);
    int order[3] = '{11, 3, 7};
    if (!gmie) return 0;
    foreach (order[i])
      if (mie[order[i]] && mip[order[i]]) return order[i];
    return 0;
  endfunction

  function automatic logic [31:0] model_read(int t, logic [2:0] a);
    case (a)
      3'd0:    return {31'b0, m_msip};
      3'd1:    return m_cmp[t][31:0];
      3'd2:    return m_cmp[t][63:32];
      3'd3:    return m_mtime[t][31:0];
      3'd4:    return m_mtime[t][63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    int          code;
    bit          we;
    logic [2:0]  a;
    logic [31:0] wd;
    bit          inc;
    we = bus.bus_we;
    a  = bus.bus_addr;
    wd = bus.bus_wdata;
    if (reset) begin
      for (int t = 0; t < 2; t++) begin
        m_mtime[t] = 64'h0;
        m_cmp[t]   = '1;
        m_mtip[t]  = 1'b0;
      end
      m_edges = 0;
      m_msip = 0; m_meip = 0; m_ext_prev = 0;
      m_req = 0; m_busy = 0; m_cause = 32'h0;
    end else begin
      code = pick(mstatus_mie, mie_in, model_mip());
      if (m_busy) begin
        if (bus.mret) m_busy = 0;
      end else if (m_req) begin
        if (bus.irq_ack) begin
          m_req = 0;
          m_busy = 1;
        end else if (code != 0) m_cause = 32'h8000_0000 | 32'(code);
        else m_req = 0;
      end else if (code != 0) begin
        m_req = 1;
        m_cause = 32'h8000_0000 | 32'(code);
      end
      for (int t = 0; t < 2; t++) begin
        m_mtip[t] = (m_mtime[t] >= m_cmp[t]);
        inc = ((m_edges % divs[t]) == divs[t] - 1);
        if (we && a == 3'd3)      m_mtime[t][31:0]  = wd;
        else if (we && a == 3'd4) m_mtime[t][63:32] = wd;
        else if (inc)             m_mtime[t] = m_mtime[t] + 64'd1;
        if (we && a == 3'd1)      m_cmp[t][31:0]  = wd;
        else if (we && a == 3'd2) m_cmp[t][63:32] = wd;
      end
      m_edges++;
      m_meip = m_ext_prev;
      m_ext_prev = ext_irq;
      if (we && a == 3'd0) m_msip = wd[0];
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_eq("irq_req", bus.irq_req, m_req);
    check_eq("irq_cause", bus.irq_cause, m_cause);
    check_eq("mip_out", mip_out, model_mip());
    check_eq("rdata", bus.bus_rdata, model_read(0, bus.bus_addr));
    check_eq("rdata_div3", bus3.bus_rdata, model_read(1, bus.bus_addr));
    check_eq("mtip_div3", mip_out3[7], m_mtip[1]);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.bus_we = 1'b1;
    bus.bus_addr = a;
    bus.bus_wdata = d;
    step();
    bus.bus_we = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int limit);
    int n = 0;
    while (!bus.irq_req && n < limit) begin
      step();
      n++;
    end
    check_eq(tag, bus.irq_req, 1'b1);
  endtask

  task automatic peek(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.bus_addr = a;
    #1;
    check_eq(tag, bus.bus_rdata, exp);
  endtask

  initial begin
    int n;
    int cnt;
    reset = 1'b1; ext_irq = 1'b0; mstatus_mie = 1'b0; mie_in = '0;
    bus.bus_we = 1'b0; bus.bus_addr = 3'd0; bus.bus_wdata = '0;
    bus.irq_ack = 1'b0; bus.mret = 1'b0;
    repeat (3) step();
    check_eq("rst_req", bus.irq_req, 1'b0);
    check_eq("rst_cause", bus.irq_cause, 32'h0);
    check_eq("rst_mip", mip_out, 32'h0);
    peek("rst_cmp_lo", 3'd1, 32'hFFFF_FFFF);
    reset = 1'b0;

    // timer interrupt
    mie_in = 32'h80; mstatus_mie = 1'b1;
    bus_write(3'd2, 32'h0);
    bus_write(3'd1, 32'd10);
    bus.bus_addr = 3'd3;
    #1;
    n = 0;
    while (bus.bus_rdata !== 32'd10 && n < 50) begin
      step();
      n++;
    end
    check_eq("tmr_reach10", bus.bus_rdata, 32'd10);
    check_eq("tmr_mip_early", mip_out[7], 1'b0);
    step();
    check_eq("tmr_mip_rise", mip_out[7], 1'b1);
    check_eq("tmr_req_early", bus.irq_req, 1'b0);
    step();
    check_eq("tmr_req_rise", bus.irq_req, 1'b1);
    check_eq("tmr_cause", bus.irq_cause, 32'h8000_0007);

    // handshake
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    check_eq("hs_ack_drop", bus.irq_req, 1'b0);
    cnt = 0;
    repeat (4) begin step(); if (bus.irq_req) cnt++; end
    check_eq("hs_blocked", cnt, 0);
    bus.mret = 1'b1; step(); bus.mret = 1'b0;
    check_eq("hs_gap", bus.irq_req, 1'b0);
    step();
    check_eq("hs_rearm", bus.irq_req, 1'b1);

    // priority: external arrives while timer request is pending
    mie_in = 32'h880; ext_irq = 1'b1;
    step(); check_eq("pri_c1", bus.irq_cause, 32'h8000_0007);
    step(); check_eq("pri_c2", bus.irq_cause, 32'h8000_0007);
    step(); check_eq("pri_c3", bus.irq_cause, 32'h8000_000B);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    check_eq("pri_ack_req", bus.irq_req, 1'b0);
    check_eq("pri_ack_cause", bus.irq_cause, 32'h8000_000B);
    ext_irq = 1'b0;
    bus_write(3'd2, 32'hFFFF_FFFF);
    repeat (3) step();
    bus.mret = 1'b1; step(); bus.mret = 1'b0;
    step();
    check_eq("clean_idle", bus.irq_req, 1'b0);

    // withdrawal by global enable
    mie_in = 32'h8;
    bus_write(3'd0, 32'h1);
    wait_req("wd_req", 5);
    check_eq("wd_cause", bus.irq_cause, 32'h8000_0003);
    mstatus_mie = 1'b0; step();
    check_eq("wd_drop", bus.irq_req, 1'b0);
    mstatus_mie = 1'b1; step();
    check_eq("wd_idle_rearm", bus.irq_req, 1'b1);

    // gating by mie
    mie_in = 32'h0; step();
    check_eq("gate_withdraw", bus.irq_req, 1'b0);
    ext_irq = 1'b1;
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h0);
    cnt = 0;
    repeat (20) begin step(); if (bus.irq_req) cnt++; end
    check_eq("gate_never", cnt, 0);
    check_eq("gate_mip", mip_out, 32'h888);
    ext_irq = 1'b0;
    bus_write(3'd0, 32'h0);
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'hFFFF_FFFF);

    // mtime wrap and write collision
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_write(3'd3, 32'hFFFF_FFFE);
    peek("wrap_start_lo", 3'd3, 32'hFFFF_FFFE);
    peek("wrap_start_hi", 3'd4, 32'hFFFF_FFFF);
    step(); step();
    peek("wrap_lo", 3'd3, 32'h0);
    peek("wrap_hi", 3'd4, 32'h0);
    bus_write(3'd3, 32'h1234);
    check_eq("coll_write", bus.bus_rdata, 32'h1234);
    step();
    check_eq("coll_next", bus.bus_rdata, 32'h1235);

    // reset while in the handler
    mie_in = 32'h8;
    bus_write(3'd0, 32'h1);
    wait_req("rst_setup_req", 5);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    check_eq("rst_in_active", bus.irq_req, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("rstm_req", bus.irq_req, 1'b0);
    check_eq("rstm_cause", bus.irq_cause, 32'h0);
    peek("rstm_mtime", 3'd3, 32'h0);
    peek("rstm_cmp_lo", 3'd1, 32'hFFFF_FFFF);
    peek("rstm_cmp_hi", 3'd2, 32'hFFFF_FFFF);
    bus_write(3'd0, 32'h1);
    wait_req("rstm_unblocked", 5);

    // random traffic against the model
    repeat (3000) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) ext_irq = ~ext_irq;
      mstatus_mie = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mie_in = $urandom;
      bus.bus_we = ($urandom_range(0, 5) == 0);
      bus.bus_addr = 3'($urandom_range(0, 7));
      bus.bus_wdata = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 60);
      bus.irq_ack = ($urandom_range(0, 3) == 0);
      bus.mret = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
